prg_load_sequencer: RTL
=======================

Name: prg_load_sequencer

Overview:
- Controller that loads the menu-selected demo program into Altair main memory without CPU involvement.
- On a load request it:
  - holds the machine in reset,
  - streams bytes from the program ROM into the memory write port,
  - then releases reset.
- Sits between the menu/reset logic and the altair machine's memory port; acts as a 2:1 port arbiter. The CPU owns the port when idle; the loader owns it while busy.

Parameters:
- ADDR_W, 16, memory address width
- OFS_W, 12, program byte offset width (max program 4096 bytes)
- HOLD_CYC, 4, machine-reset cycles asserted before and after the copy

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- load_req  in  1  level from OSD "Load Program"; rising edge starts a load
- prg_sel  in  3  program index, sampled on load_req rising edge
- prg_len  in  OFS_W+1  byte count for latched program, from external table indexed by sel_q
- prg_base  in  ADDR_W  destination start address for latched program
- sel_q  out  3  latched program index
- rom_addr  out  3+OFS_W  {sel_q, offset} to synchronous program ROM
- rom_data  in  8  ROM byte, valid one cycle after rom_addr
- cpu_addr  in  ADDR_W  CPU memory address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- mem_addr  out  ADDR_W  arbitrated memory address
- mem_wdata  out  8  arbitrated write data
- mem_we  out  1  arbitrated write strobe
- machine_reset  out  1  reset to machine; high while busy
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values:
  - state IDLE, sel_q=0, offset=0, count=0, load_req edge register=0.
  - Outputs: machine_reset=0, busy=0, done=0, mem_we=cpu_we (mux in CPU position), rom_addr=0.
- Edge detect: start = load_req & ~load_req_d. Sampling is registered, so one cycle passes before state leaves IDLE. Only one load is started per rising edge.
- States:
  - IDLE: mux selects CPU (mem_* = cpu_* combinationally). On start: sel_q<=prg_sel, offset<=0, count<=0 -> HOLD1.
  - HOLD1: machine_reset=1. Count HOLD_CYC cycles, then:
    - -> FETCH if prg_len!=0,
    - -> HOLD2 if prg_len==0 (Empty program still performs the reset).
  - FETCH: rom_addr={sel_q,offset}; mem_we=0 -> WRITE.
  - WRITE: mem_addr=prg_base+offset (modulo 2^ADDR_W, wraps past FFFF to 0000); mem_wdata=rom_data; mem_we=1 for exactly this cycle. Then offset+1:
    - if offset+1==prg_len -> HOLD2,
    - else -> FETCH.
  - HOLD2: machine_reset=1 for HOLD_CYC cycles -> DONE.
  - DONE: machine_reset=0, done=1 for one cycle -> IDLE.
- Arbitration:
  - Busy in HOLD1..DONE. While busy, cpu_we is ignored: never forwarded, even though the CPU is in reset.
  - When not writing, the loader drives mem_we=0.
- Latency: N bytes -> busy for HOLD_CYC + 2N + HOLD_CYC + 1 cycles. 1 write per 2 cycles.
- load_req edges while busy: ignored, not queued.
- prg_sel and prg_len changes while busy: no effect on the load in progress. prg_len is read via sel_q, which is stable.
- prg_len > 2^OFS_W: saturate to 2^OFS_W bytes.
- Async reset mid-load: immediate return to IDLE, machine_reset=0, port returns to CPU. Partially written memory is not restored.

Test Plan:
- Reset, load_req=0, cpu_we=1, cpu_addr=0x1234, cpu_wdata=0x5A -> mem_we=1, mem_addr=0x1234, mem_wdata=0x5A; busy=0; machine_reset=0.
- prg_sel=1, prg_len=8, prg_base=0x0000, load_req rises, HOLD_CYC=4 -> machine_reset high for 4+16+4 cycles. Exactly 8 mem_we pulses, 2 cycles apart, addresses 0x0000..0x0007 carrying ROM bytes {1,0..7}. Then done pulses once and busy falls.
- prg_sel=0, prg_len=0 -> zero mem_we pulses; machine_reset high for 8 cycles; done pulses.
- prg_base=0xFFFE, prg_len=4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- During load: toggle load_req, change prg_sel to 5, pulse cpu_we -> no restart, sel_q unchanged, no CPU write reaches mem_we.
- Assert reset after 3rd write of an 8-byte load -> same cycle: busy=0, machine_reset=0, mux returns to CPU. A later load_req edge restarts the load from offset 0.

Source files
------------

// File: rtl/prg_load_sequencer_if.sv
// Bundles the sequencer's port toward the menu/ROM side and the memory port.
// master: the load sequencer.
// slave: the surrounding logic (program table, ROM, CPU, machine).
interface prg_load_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int OFS_W  = 12
);
  logic                  load_req;
  logic [2:0]            prg_sel;
  logic [OFS_W:0]        prg_len;
  logic [ADDR_W-1:0]     prg_base;
  logic [2:0]            sel_q;
  logic [3+OFS_W-1:0]    rom_addr;
  logic [7:0]            rom_data;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_we;
  logic                  machine_reset;
  logic                  busy;
  logic                  done;

  modport master (
    input  load_req, prg_sel, prg_len, prg_base, rom_data,
           cpu_addr, cpu_wdata, cpu_we,
    output sel_q, rom_addr, mem_addr, mem_wdata, mem_we,
           machine_reset, busy, done
  );

  modport slave (
    output load_req, prg_sel, prg_len, prg_base, rom_data,
           cpu_addr, cpu_wdata, cpu_we,
    input  sel_q, rom_addr, mem_addr, mem_wdata, mem_we,
           machine_reset, busy, done
  );
endinterface

// File: rtl/prg_load_sequencer.sv
// Copies the selected demo program from ROM into main memory while holding
// the machine in reset, arbitrating the memory port between CPU and loader.
module prg_load_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int OFS_W    = 12,
  parameter int HOLD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  prg_load_sequencer_if.master bus
);

  localparam int CNT_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [OFS_W:0]   MAX_LEN   = {1'b1, {OFS_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD1,
    S_FETCH,
    S_WRITE,
    S_HOLD2,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_sel_q;
  logic [2:0]       w_sel_next;
  logic [OFS_W:0]   r_offset;
  logic [OFS_W:0]   w_offset_next;
  logic [OFS_W:0]   w_offset_inc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_load_req_d;
  logic             w_start;
  logic [OFS_W:0]   w_len;

  // Programs longer than the offset space are clamped to the full ROM slot.
  assign w_len        = (bus.prg_len > MAX_LEN) ? MAX_LEN : bus.prg_len;
  assign w_start      = bus.load_req & ~r_load_req_d;
  assign w_offset_inc = r_offset + 1'b1;

  // Rising-edge detector for load_req; tracks the level in every state so
  // edges seen while busy are consumed rather than queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_req_d <= 1'b0;
    end else begin
      r_load_req_d <= bus.load_req;
    end
  end

  // State, latched program index, byte offset and hold-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sel_q  <= 3'd0;
      r_offset <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_sel_q  <= w_sel_next;
      r_offset <= w_offset_next;
      r_count  <= w_count_next;
    end
  end

  // Next-state logic for the load sequence.
  always_comb begin
    w_state_next  = r_state;
    w_sel_next    = r_sel_q;
    w_offset_next = r_offset;
    w_count_next  = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_sel_next    = bus.prg_sel;
          w_offset_next = '0;
          w_count_next  = '0;
          w_state_next  = S_HOLD1;
        end
      end
      S_HOLD1: begin
        if (r_count == HOLD_LAST) begin
          w_count_next = '0;
          // An empty program still gets the full reset pulse.
          w_state_next = (w_len == '0) ? S_HOLD2 : S_FETCH;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      S_FETCH: begin
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_offset_next = w_offset_inc;
        w_state_next  = (w_offset_inc == w_len) ? S_HOLD2 : S_FETCH;
      end
      S_HOLD2: begin
        if (r_count == HOLD_LAST) begin
          w_count_next = '0;
          w_state_next = S_DONE;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs and the ROM address, which stays put across FETCH/WRITE
  // so the synchronous ROM byte is valid during WRITE.
  always_comb begin
    bus.busy          = (r_state != S_IDLE);
    bus.machine_reset = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.done          = (r_state == S_DONE);
    bus.sel_q         = r_sel_q;
    bus.rom_addr      = {r_sel_q, r_offset[OFS_W-1:0]};
  end

  // Memory port mux: CPU owns it in IDLE, loader owns it otherwise and only
  // strobes during WRITE. Destination address wraps modulo 2^ADDR_W.
  always_comb begin
    if (r_state == S_IDLE) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we;
    end else begin
      bus.mem_addr  = bus.prg_base + ADDR_W'(r_offset);
      bus.mem_wdata = bus.rom_data;
      bus.mem_we    = (r_state == S_WRITE);
    end
  end

endmodule
